// File: rtl/chunked_alu_pkg.sv
// rtl/chunked_alu_pkg.sv - shared op/state encodings for the chunked ALU
package chunked_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_XOR = 2'd2,
    OP_AND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk counter width, never narrower than one bit.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_alu_if.sv
// rtl/chunked_alu_if.sv - operand/result handshake bundle; CHUNKED_ALU_OVF_EN adds overflow
interface chunked_alu_if
  import chunked_alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
`ifdef CHUNKED_ALU_OVF_EN
  logic             overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, zero, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, zero, overflow
  );
`else
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, zero
  );
`endif
endinterface

// File: rtl/chunk_alu_slice.sv
// rtl/chunk_alu_slice.sv - combinational CHUNK-bit add/sub/xor/and slice
module chunk_alu_slice
  import chunked_alu_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             carry_in,
  input  op_e              op,
  output logic [CHUNK-1:0] r_chunk,
  output logic             carry_out,
  output logic             msb_carry_in
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  always_comb begin
    b_eff        = (op == OP_SUB) ? ~b_chunk : b_chunk;
    sum          = {1'b0, a_chunk} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_in};
    r_chunk      = sum[CHUNK-1:0];
    carry_out    = 1'b0;
    msb_carry_in = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        carry_out    = sum[CHUNK];
        // Undo the top-bit sum to recover the carry that entered it.
        msb_carry_in = a_chunk[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1];
      end
      OP_XOR:  r_chunk = a_chunk ^ b_chunk;
      default: r_chunk = a_chunk & b_chunk;
    endcase
  end

endmodule

// File: rtl/chunked_alu_seq.sv
// rtl/chunked_alu_seq.sv - multi-cycle ALU, CHUNK bits per clock LSB first; CHUNKED_ALU_OVF_EN adds overflow
module chunked_alu_seq
  import chunked_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  chunked_alu_if.slave     bus
);

  localparam int            NCHUNK   = WIDTH / CHUNK;
  localparam int            CW       = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_e              op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] slice_r;
  logic             slice_cout;
  logic             slice_msb_cin;

  chunk_alu_slice #(.CHUNK(CHUNK)) u_slice (
    .a_chunk      (a_q[cnt_q*CHUNK +: CHUNK]),
    .b_chunk      (b_q[cnt_q*CHUNK +: CHUNK]),
    .carry_in     (carry_q),
    .op           (op_q),
    .r_chunk      (slice_r),
    .carry_out    (slice_cout),
    .msb_carry_in (slice_msb_cin)
  );

`ifdef CHUNKED_ALU_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_msb_cin;
  assign unused_msb_cin = slice_msb_cin;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef CHUNKED_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = (bus.op == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q*CHUNK +: CHUNK] = slice_r;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          zero_d  = (result_d == '0);
`ifdef CHUNKED_ALU_OVF_EN
          ovf_d   = slice_msb_cin ^ slice_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef CHUNKED_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef CHUNKED_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
`ifdef CHUNKED_ALU_OVF_EN
  assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_alu_seq.sv
// tb/tb_chunked_alu_seq.sv - randomized model check of chunked_alu_seq (16/4 and 3/1); honours CHUNKED_ALU_OVF_EN
module tb_chunked_alu_seq;
  import chunked_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chunked_alu_if #(.WIDTH(16)) bus ();
  chunked_alu_if #(.WIDTH(3))  bus3 ();

  chunked_alu_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  chunked_alu_seq #(.WIDTH(3), .CHUNK(1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: w-bit modular arithmetic. Returns {overflow, carry, result[63:0]}.
  function automatic logic [65:0] model(int w, logic [1:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] mask;
    logic [64:0] s;
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        sb;
    mask = (64'd1 << w) - 64'd1;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        sb = b[w-1];
      end
      2'd1: begin
        s  = {1'b0, a} + {1'b0, (~b) & mask} + 65'd1;
        sb = ~b[w-1];
      end
      2'd2: begin
        s  = {1'b0, a ^ b};
        sb = 1'b0;
      end
      default: begin
        s  = {1'b0, a & b};
        sb = 1'b0;
      end
    endcase
    r = s[63:0] & mask;
    if (op < 2'd2) begin
      c = s[w];
      v = (a[w-1] == sb) && (r[w-1] != a[w-1]);
    end
    return {v, c, r};
  endfunction

  task automatic issue(op_e op, logic [15:0] a, logic [15:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.op       = op_e'($urandom_range(0, 3));
  endtask

  task automatic collect(op_e op, logic [15:0] a, logic [15:0] b, int stall);
    logic [65:0] m;
    int          n;
    m = model(16, op, {48'd0, a}, {48'd0, b});
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'd4);
    chk("result", {48'd0, bus.result}, m[63:0]);
    chk("carry_out", {63'd0, bus.carry_out}, {63'd0, m[64]});
    chk("zero", {63'd0, bus.zero}, 64'(m[63:0] == 64'd0));
`ifdef CHUNKED_ALU_OVF_EN
    chk("overflow", {63'd0, bus.overflow}, {63'd0, m[65]});
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_result", {48'd0, bus.result}, m[63:0]);
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", {63'd0, bus.out_valid}, 64'd0);
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic op_run(op_e op, logic [15:0] a, logic [15:0] b, int stall);
    issue(op, a, b);
    collect(op, a, b, stall);
  endtask

  initial begin
    op_e         op;
    op_e         op2;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] a2;
    logic [15:0] b2;
    logic [65:0] m;
    int          n;
    int          stray;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
    bus.op = OP_ADD;      bus.a = '0; bus.b = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
    bus3.op = OP_ADD;     bus3.a = '0; bus3.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", {48'd0, bus.result}, 64'd0);
    chk("rst_carry", {63'd0, bus.carry_out}, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd0);
    chk("rst3_in_ready", {63'd0, bus3.in_ready}, 64'd1);
    chk("rst3_out_valid", {63'd0, bus3.out_valid}, 64'd0);
`ifdef CHUNKED_ALU_OVF_EN
    chk("rst_overflow", {63'd0, bus.overflow}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    op_run(OP_XOR, 16'b1010001110001100, 16'b0110001110010000, 0);
    op_run(OP_SUB, 16'h0005, 16'h0007, 0);
    op_run(OP_SUB, 16'h0007, 16'h0007, 1);
    op_run(OP_ADD, 16'h7FFF, 16'h0001, 0);
    op_run(OP_SUB, 16'h8000, 16'h0001, 0);
    op_run(OP_AND, 16'hF0F0, 16'h0F0F, 0);

    op_run(OP_ADD, 16'h1234, 16'h4321, 10);
    op_run(OP_ADD, 16'hFFFF, 16'h0001, 0);

    // Second request held on in_valid while the first is still in flight.
    a  = 16'($urandom); b  = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom);
    op = OP_SUB; op2 = OP_ADD;
    issue(op, a, b);
    bus.in_valid = 1'b1; bus.op = op2; bus.a = a2; bus.b = b2;
    collect(op, a, b, 3);
    issue(op2, a2, b2);
    collect(op2, a2, b2, 0);

    // Reset with two chunks done: the operation must vanish.
    issue(OP_ADD, 16'($urandom), 16'($urandom));
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("midrst_result", {48'd0, bus.result}, 64'd0);
    chk("midrst_carry", {63'd0, bus.carry_out}, 64'd0);
    stray = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray++;
    end
    chk("midrst_stray_valid", 64'(stray), 64'd0);

    for (int i = 0; i < 150; i++) begin
      op_run(op_e'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
    end

    // Single-bit chunks on a 3-bit datapath, every op and operand pair.
    for (int o = 0; o < 4; o++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          m = model(3, 2'(o), 64'(x), 64'(y));
          bus3.in_valid = 1'b1;
          bus3.op = op_e'(o); bus3.a = 3'(x); bus3.b = 3'(y);
          @(posedge clk); #1;
          bus3.in_valid = 1'b0;
          bus3.a = 3'($urandom); bus3.b = 3'($urandom);
          n = 0;
          while (!bus3.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
          end
          chk("w3_latency", 64'(n), 64'd3);
          chk("w3_result", {61'd0, bus3.result}, m[63:0]);
          chk("w3_carry", {63'd0, bus3.carry_out}, {63'd0, m[64]});
          chk("w3_zero", {63'd0, bus3.zero}, 64'(m[63:0] == 64'd0));
`ifdef CHUNKED_ALU_OVF_EN
          chk("w3_overflow", {63'd0, bus3.overflow}, {63'd0, m[65]});
`endif
          bus3.out_ready = 1'b1;
          @(posedge clk); #1;
          bus3.out_ready = 1'b0;
          chk("w3_idle", {63'd0, bus3.in_ready}, 64'd1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
